// File: rtl/round_countdown_timer.sv
// round_countdown_timer
//   Game-round countdown driven by the free-running centisecond timestamp of
//   the system clock block. Every observed change of the timestamp is one
//   elapsed centisecond. Supports start / pause / resume / abort. Issues a
//   one-cycle expiry pulse when the round reaches 0 s / 0 cs.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   timestamp      20-bit centisecond count (wraps to 0)
//   start          load duration_sec (clamped to MAX_SEC) and run
//   duration_sec   round length in seconds, sampled on start
//   pause/resume   pause / resume strobes
//   abort          cancel round, return to IDLE
//   remaining_sec  whole seconds left
//   remaining_cs   centiseconds left, 0..99
//   elapsed_cs     centiseconds counted while RUNNING this round (saturating)
//   running/paused/done  state decode (done = EXPIRED)
//   expired        one-cycle pulse on entry to EXPIRED
//   warning        low-time indicator while running or paused
module round_countdown_timer #(
   parameter int MAX_SEC  = 99,
   parameter int WARN_SEC = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] timestamp,
   input  logic        start,
   input  logic [6:0]  duration_sec,
   input  logic        pause,
   input  logic        resume,
   input  logic        abort,
   output logic [6:0]  remaining_sec,
   output logic [6:0]  remaining_cs,
   output logic [19:0] elapsed_cs,
   output logic        running,
   output logic        paused,
   output logic        done,
   output logic        expired,
   output logic        warning
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_PAUSED  = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t      r_state;
   logic [19:0] r_ts_prev;
   logic        r_ts_valid;
   logic [6:0]  r_sec;
   logic [6:0]  r_cs;
   logic [19:0] r_elapsed;
   logic        r_expired;

   logic        w_tick;
   logic [6:0]  w_load;

   // Any change of the source is exactly one tick, including wrap and jumps.
   assign w_tick = r_ts_valid && (timestamp != r_ts_prev);
   assign w_load = (duration_sec > 7'(MAX_SEC)) ? 7'(MAX_SEC) : duration_sec;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ts_prev  <= '0;
         r_ts_valid <= 1'b0;
         r_sec      <= '0;
         r_cs       <= '0;
         r_elapsed  <= '0;
         r_expired  <= 1'b0;
      end else begin
         r_ts_prev  <= timestamp;
         r_ts_valid <= 1'b1;
         r_expired  <= 1'b0;
         if (abort) begin
            // elapsed_cs is deliberately held so the HUD can show it
            r_state <= S_IDLE;
            r_sec   <= '0;
            r_cs    <= '0;
         end else if (start) begin
            r_sec     <= w_load;
            r_cs      <= '0;
            r_elapsed <= '0;
            if (w_load == '0) begin
               r_state   <= S_EXPIRED;
               r_expired <= 1'b1;
            end else begin
               r_state <= S_RUNNING;
            end
         end else if (pause || resume) begin
            // Any pause/resume strobe consumes the cycle: a coincident tick
            // is dropped even when the strobe itself has no effect.
            if (pause && !resume && r_state == S_RUNNING)
               r_state <= S_PAUSED;
            else if (resume && !pause && r_state == S_PAUSED)
               r_state <= S_RUNNING;
         end else if (w_tick && r_state == S_RUNNING) begin
            if (r_elapsed != '1)
               r_elapsed <= r_elapsed + 20'd1;
            if (r_sec == '0 && r_cs <= 7'd1) begin
               r_sec     <= '0;
               r_cs      <= '0;
               r_state   <= S_EXPIRED;
               r_expired <= 1'b1;
            end else if (r_cs != '0) begin
               r_cs <= r_cs - 7'd1;
            end else begin
               r_cs  <= 7'd99;
               r_sec <= r_sec - 7'd1;
            end
         end
      end
   end

   assign remaining_sec = r_sec;
   assign remaining_cs  = r_cs;
   assign elapsed_cs    = r_elapsed;
   assign running       = (r_state == S_RUNNING);
   assign paused        = (r_state == S_PAUSED);
   assign done          = (r_state == S_EXPIRED);
   assign expired       = r_expired;
   assign warning       = (running || paused) && (r_sec < 7'(WARN_SEC));

endmodule

// File: doc/round_countdown_timer.md
Name: round_countdown_timer

Overview:
- Consumes the free-running 20-bit centisecond timestamp from the system clock block. Each observed timestamp change counts as one elapsed centisecond.
- Runs a game-round countdown with start, pause, resume and abort, and drives the seconds/centiseconds display fields.
- Issues a one-cycle expiry pulse to the game-control FSM when the round time reaches zero.
- Sits between the system clock block and the game-control and score/HUD logic.

Parameters:
- MAX_SEC, 99: upper clamp for the loaded duration, in seconds.
- WARN_SEC, 10: `warning` asserts while running or paused with remaining_sec < WARN_SEC.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- timestamp  in  20  centisecond count from the system clock block; wraps to 0
- start  in  1  load duration and begin countdown (single-cycle strobe)
- duration_sec  in  7  round length in seconds, sampled on start
- pause  in  1  pause strobe
- resume  in  1  resume strobe
- abort  in  1  cancel round, return to IDLE
- remaining_sec  out  7  whole seconds left
- remaining_cs  out  7  centiseconds left, 0..99
- elapsed_cs  out  20  centiseconds counted while RUNNING this round; saturating
- running  out  1  state == RUNNING
- paused  out  1  state == PAUSED
- done  out  1  state == EXPIRED
- expired  out  1  one-cycle pulse on entry to EXPIRED
- warning  out  1  low-time indicator

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- On reset: state IDLE, all outputs 0, ts_prev = 0, ts_valid = 0.
- Tick detect:
  - The first clock after reset captures timestamp into ts_prev, sets ts_valid, and produces no tick.
  - After that, tick = ts_valid && (timestamp != ts_prev). ts_prev updates every cycle.
  - Wrap to 0 counts as one tick. Any jump of the source counts as exactly one tick (no multi-tick catch-up).
- Latency: a tick sampled at edge k updates remaining/elapsed at that same edge, so outputs are visible one cycle after timestamp changes.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Command priority, evaluated each edge: abort > start > pause/resume > tick.
  - abort (any state): go to IDLE, clear remaining_sec and remaining_cs to 0, hold elapsed_cs, no expired pulse.
  - start (any state, including mid-round restart):
    - Load remaining_sec = min(duration_sec, MAX_SEC) and remaining_cs = 0.
    - Clear elapsed_cs.
    - If the loaded value is 0, go to EXPIRED and pulse expired on the next cycle. Otherwise go to RUNNING.
    - A tick coinciding with start is ignored.
  - pause: RUNNING → PAUSED, and a tick in the same cycle is ignored. Ignored in all other states.
  - resume: PAUSED → RUNNING, and a tick in the same cycle is ignored. Ignored in all other states.
  - pause and resume in the same cycle: no state change, tick ignored.
- RUNNING tick, with no command that cycle:
  - elapsed_cs += 1, saturating at 20'hFFFFF.
  - If remaining_cs != 0: remaining_cs -= 1. Otherwise remaining_cs = 99 and remaining_sec -= 1.
  - If the pre-tick value is 0 s / 1 cs: result is 0/0, go to EXPIRED, expired = 1 for exactly one cycle (registered, same edge as state entry).
- PAUSED and IDLE: ticks ignored, all counters held.
- EXPIRED: counters held at 0/0, done = 1. Leaves only on start or abort.
- Arithmetic: two-field down counter only, no divider. remaining_cs is never outside 0..99. remaining_sec never underflows.
- warning = (running | paused) && remaining_sec < WARN_SEC. It is 0 in IDLE and EXPIRED.

Test Plan:
- Reset, then start with duration_sec = 3 and timestamp incrementing every 10 clk → remaining goes 3/0, 2/99 … 0/0 after 300 ticks. expired is high for exactly 1 cycle, done stays 1, elapsed_cs = 300.
- timestamp stepping 1000000 → 1000001 → 0 → 1 during RUNNING with 5/0 loaded → three decrements, final 4/97. Wrap is counted as exactly one tick.
- Start 2 s, pause after 50 ticks, apply 100 timestamp changes, then resume → remaining holds at 1/50 while paused. paused = 1, running = 0. Countdown continues from 1/50 after resume.
- start with duration_sec = 120 (MAX_SEC = 99) → loads 99/0. Start with duration_sec = 0 → EXPIRED next cycle with a one-cycle expired pulse.
- Abort asserted together with start and a tick while RUNNING at 7/33 → IDLE, remaining 0/0, no expired pulse, elapsed_cs unchanged.
- Assert reset for one cycle mid-countdown → all outputs 0, state IDLE. The first timestamp change after reset produces no tick. Countdown stays at 0/0 until the next start.
